// File: rtl/canny_accel_mac_pkg.sv
// Shared helpers for the canny_accel multiply-accumulate pipeline and the
// blocks that reuse its round/saturate stage.
package canny_accel_mac_pkg;

  localparam int MIN_STAGES = 3;
  localparam int MAX_STAGES = 8;
  // Widest accumulator the limit helpers can describe.
  localparam int LIM_W      = 128;

  // Full-precision product width, with one guard bit for mixed signedness.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  // Largest two's complement value representable in w bits.
  function automatic logic signed [LIM_W-1:0] sat_max(input int w);
    logic signed [LIM_W-1:0] one;
    one = LIM_W'(1);
    return (one <<< (w - 1)) - LIM_W'(1);
  endfunction

  // Smallest two's complement value representable in w bits.
  function automatic logic signed [LIM_W-1:0] sat_min(input int w);
    return -sat_max(w) - LIM_W'(1);
  endfunction

  function automatic bit stages_ok(input int s);
    return (s >= MIN_STAGES) && (s <= MAX_STAGES);
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int a_w, input int b_w);
    return (acc_w >= prod_width(a_w, b_w)) && (acc_w < LIM_W);
  endfunction

endpackage

// File: rtl/canny_accel_mac_round_sat.sv
// Round-half-up arithmetic right shift followed by an optional clamp to the
// output width. Purely combinational; shared with the NMS scaling path.
module canny_accel_mac_round_sat
  import canny_accel_mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int SHIFT = 0,
  parameter int OUT_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic signed [ACC_W-1:0] value,
  output logic signed [OUT_W-1:0] p,
  output logic                    sat
);

  // One extra bit so adding the rounding bias can never wrap.
  localparam int EW = ACC_W + 1;
  localparam logic signed [EW-1:0] BIAS =
    (SHIFT > 0) ? (EW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [EW-1:0] O_MAX = EW'(sat_max(OUT_W));
  localparam logic signed [EW-1:0] O_MIN = EW'(sat_min(OUT_W));

  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] r;
  logic                 above;
  logic                 below;

  // Bias, shift toward -inf, then clamp or wrap into OUT_W bits.
  always_comb begin
    biased = EW'(value) + BIAS;
    r      = biased >>> SHIFT;
    above  = (r > O_MAX);
    below  = (r < O_MIN);
    p      = r[OUT_W-1:0];
    if (SAT && above) begin
      p = O_MAX[OUT_W-1:0];
    end else if (SAT && below) begin
      p = O_MIN[OUT_W-1:0];
    end
    sat = SAT && (above || below);
  end

endmodule

// File: rtl/canny_accel_mac_pipe.sv
// Pipelined multiply-accumulate: S1 operand capture, S2 multiply,
// S3..S(STAGES-1) delay, S(STAGES) accumulate + round/saturate + output.
module canny_accel_mac_pipe
  import canny_accel_mac_pkg::*;
#(
  parameter int A_W      = 17,
  parameter int B_W      = 14,
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b0,
  parameter int STAGES   = 4,
  parameter int ACC_W    = 40,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 32,
  parameter bit SAT      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic             ovf
);

  localparam int PW  = prod_width(A_W, B_W);
  localparam int DLY = STAGES - 2;  // registers S2 .. S(STAGES-1)
  localparam int T   = DLY - 1;     // index feeding the last stage
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("canny_accel_mac_pipe: STAGES=%0d must be within 3..8", STAGES);
  end
  if (!acc_w_ok(ACC_W, A_W, B_W)) begin : g_bad_acc_w
    $error("canny_accel_mac_pipe: ACC_W=%0d must be >= A_W+B_W+1 and < 128", ACC_W);
  end
  if ((OUT_W > ACC_W) || (SHIFT < 0) || (SHIFT >= ACC_W)) begin : g_bad_scale
    $error("canny_accel_mac_pipe: need OUT_W <= ACC_W and 0 <= SHIFT < ACC_W");
  end

  // Handshake: one global advance, adv = !out_valid || out_ready. A beat
  // moves in when in_valid && in_ready (in_ready == adv); a result leaves when
  // out_valid && out_ready. With adv low every stage and the accumulator hold.
  logic adv;

  logic                    s1_valid_q, s1_valid_d;
  logic [A_W-1:0]          s1_a_q, s1_a_d;
  logic [B_W-1:0]          s1_b_q, s1_b_d;
  logic                    s1_en_q, s1_en_d;
  logic                    s1_clr_q, s1_clr_d;

  logic signed [PW-1:0]    a_ext, b_ext, prod;

  logic                    pv_q    [DLY];
  logic                    pv_d    [DLY];
  logic signed [PW-1:0]    pprod_q [DLY];
  logic signed [PW-1:0]    pprod_d [DLY];
  logic                    pen_q   [DLY];
  logic                    pen_d   [DLY];
  logic                    pclr_q  [DLY];
  logic                    pclr_d  [DLY];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] value;
  logic                    value_sat;
  logic [OUT_W-1:0]        rs_p;
  logic                    rs_sat;

  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        p_q, p_d;
  logic                    ovf_q, ovf_d;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;

  // S1: capture the incoming beat whenever the pipe advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_en_d    = s1_en_q;
    s1_clr_d   = s1_clr_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_en_d    = acc_en;
      s1_clr_d   = acc_clr;
    end
  end

  // S2 input: extend each operand per its signedness and multiply.
  always_comb begin
    if (A_SIGNED) a_ext = PW'($signed(s1_a_q));
    else          a_ext = PW'($unsigned(s1_a_q));
    if (B_SIGNED) b_ext = PW'($signed(s1_b_q));
    else          b_ext = PW'($unsigned(s1_b_q));
    prod = a_ext * b_ext;
  end

  // S2 .. S(STAGES-1): product register followed by pure delay.
  always_comb begin
    pv_d    = pv_q;
    pprod_d = pprod_q;
    pen_d   = pen_q;
    pclr_d  = pclr_q;
    if (adv) begin
      pv_d[0]    = s1_valid_q;
      pprod_d[0] = prod;
      pen_d[0]   = s1_en_q;
      pclr_d[0]  = s1_clr_q;
      for (int k = 1; k < DLY; k++) begin
        pv_d[k]    = pv_q[k-1];
        pprod_d[k] = pprod_q[k-1];
        pen_d[k]   = pen_q[k-1];
        pclr_d[k]  = pclr_q[k-1];
      end
    end
  end

  // Last stage: pick product or saturated running sum as the value to scale.
  always_comb begin
    prod_ext  = ACC_W'(pprod_q[T]);
    acc_sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
    value     = prod_ext;
    value_sat = 1'b0;
    if (pen_q[T] && !pclr_q[T]) begin
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
        value     = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        value_sat = 1'b1;
      end else begin
        value = acc_sum[ACC_W-1:0];
      end
    end
  end

  canny_accel_mac_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_round_sat (
    .value (value),
    .p     (rs_p),
    .sat   (rs_sat)
  );

  // Output register and accumulator update, only for a valid beat on advance.
  always_comb begin
    out_valid_d = out_valid_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (adv) begin
      out_valid_d = pv_q[T];
      if (pv_q[T]) begin
        p_d   = rs_p;
        ovf_d = rs_sat || value_sat;
        if (pen_q[T]) acc_d = value;
      end
    end
  end

  // Control state: valids, accumulator and outputs clear on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      for (int k = 0; k < DLY; k++) pv_q[k] <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      pv_q        <= pv_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
    end
  end

  // Datapath registers: meaningless while their valid is low, so no reset.
  always_ff @(posedge clk) begin
    s1_a_q   <= s1_a_d;
    s1_b_q   <= s1_b_d;
    s1_en_q  <= s1_en_d;
    s1_clr_q <= s1_clr_d;
    pprod_q  <= pprod_d;
    pen_q    <= pen_d;
    pclr_q   <= pclr_d;
  end

endmodule
